// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - fetch unit bus: instruction memory handshake plus decoder/writeback hand-off
interface ifu_fetch_if;
   logic        imem_req_valid;
   logic [31:0] imem_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rdata;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic        IFU_done;
   logic        IDU_ready;
   logic        next_pc_valid;
   logic [31:0] next_pc;
   logic        fetch_err;
   logic [31:0] fetch_cnt;

   modport master (
      output imem_req_valid, imem_addr, instruction, pc, IFU_done, fetch_err, fetch_cnt,
      input  imem_req_ready, imem_rsp_valid, imem_rdata, IDU_ready, next_pc_valid, next_pc
   );

   modport slave (
      input  imem_req_valid, imem_addr, instruction, pc, IFU_done, fetch_err, fetch_cnt,
      output imem_req_ready, imem_rsp_valid, imem_rdata, IDU_ready, next_pc_valid, next_pc
   );
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - single-outstanding instruction fetch FSM with timeout and sticky error
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          MAX_WAIT = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   ifu_fetch_if.master  bus
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, WAIT_PC, ERR} state_t;

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] cnt_q, cnt_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        req_valid_q, req_valid_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      cnt_d      = cnt_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (bus.imem_req_ready) begin
               state_d    = WAIT;
               wait_cnt_d = '0;
            end
         end
         WAIT: begin
            // a response in the timeout cycle still wins over ERR
            if (bus.imem_rsp_valid) begin
               instr_d = bus.imem_rdata;
               state_d = DONE;
            end else if (wait_cnt_q == MAX_WAIT_C) begin
               state_d = ERR;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         DONE: begin
            if (bus.IDU_ready) begin
               cnt_d = cnt_q + 32'd1;
               if (bus.next_pc_valid) begin
                  pc_d    = bus.next_pc;
                  state_d = (bus.next_pc[1:0] != 2'b00) ? ERR : REQ;
               end else begin
                  state_d = WAIT_PC;
               end
            end
         end
         WAIT_PC: begin
            if (bus.next_pc_valid) begin
               pc_d    = bus.next_pc;
               state_d = (bus.next_pc[1:0] != 2'b00) ? ERR : REQ;
            end
         end
         ERR:     state_d = ERR;
         default: state_d = ERR;
      endcase
      req_valid_d = (state_d == REQ);
      done_d      = (state_d == DONE);
      err_d       = (state_d == ERR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         instr_q     <= '0;
         cnt_q       <= '0;
         wait_cnt_q  <= '0;
         req_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         cnt_q       <= cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         req_valid_q <= req_valid_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign bus.imem_req_valid = req_valid_q;
   assign bus.imem_addr      = pc_q;
   assign bus.instruction    = instr_q;
   assign bus.pc             = pc_q;
   assign bus.IFU_done       = done_q;
   assign bus.fetch_err      = err_q;
   assign bus.fetch_cnt      = cnt_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - scoreboard bench for ifu_fetch: directed fetch, hold, redirect, timeout, reset and error cases
module tb_ifu_fetch;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   ifu_fetch_if bus();

   ifu_fetch #(.RESET_PC(32'h8000_0000), .MAX_WAIT(255)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_addr_q[$];
   logic [63:0] exp_xfer_q[$];
   logic [63:0] mon_e;
   logic [31:0] mon_a;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // From REQ: accept, spend gap empty WAIT cycles, then respond; ends in DONE
   task automatic fetch_from_req(input logic [31:0] data, input int gap);
      step();
      repeat (gap) step();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rdata     = data;
      step();
      bus.imem_rsp_valid = 1'b0;
   endtask

   // Monitor: compare every accepted request and every decoder transfer against the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            if (exp_addr_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL req_unexpected: got addr %h expected no request", bus.imem_addr);
            end else begin
               mon_a = exp_addr_q.pop_front();
               check("req_addr", bus.imem_addr, mon_a);
            end
         end
         if (bus.IFU_done && bus.IDU_ready) begin
            if (exp_xfer_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL xfer_unexpected: got pc %h instr %h expected no transfer", bus.pc, bus.instruction);
            end else begin
               mon_e = exp_xfer_q.pop_front();
               check("xfer_pc", bus.pc, mon_e[63:32]);
               check("xfer_instr", bus.instruction, mon_e[31:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of stimulus");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rdata     = '0;
      bus.IDU_ready      = 1'b0;
      bus.next_pc_valid  = 1'b0;
      bus.next_pc        = '0;

      // asynchronous reset, checked before any clock edge
      #2 rst_n = 1'b0;
      #1;
      check("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
      check("rst_done", {31'd0, bus.IFU_done}, 32'd0);
      check("rst_err", {31'd0, bus.fetch_err}, 32'd0);
      check("rst_pc", bus.pc, 32'h8000_0000);
      check("rst_instr", bus.instruction, 32'd0);
      check("rst_cnt", bus.fetch_cnt, 32'd0);

      // best-case first fetch
      repeat (2) @(negedge clk);
      bus.imem_req_ready = 1'b1;
      bus.IDU_ready      = 1'b1;
      exp_addr_q.push_back(32'h8000_0000);
      exp_xfer_q.push_back({32'h8000_0000, 32'h0000_0413});
      rst_n = 1'b1;
      step();
      check("lat_c2_req", {31'd0, bus.imem_req_valid}, 32'd1);
      check("lat_c2_done", {31'd0, bus.IFU_done}, 32'd0);
      step();
      check("lat_c3_done", {31'd0, bus.IFU_done}, 32'd0);
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rdata     = 32'h0000_0413;
      step();
      bus.imem_rsp_valid = 1'b0;
      check("lat_c4_done", {31'd0, bus.IFU_done}, 32'd1);
      check("lat_c4_instr", bus.instruction, 32'h0000_0413);
      step();
      check("first_cnt", bus.fetch_cnt, 32'd1);
      check("waitpc_done", {31'd0, bus.IFU_done}, 32'd0);

      // redirect from WAIT_PC, then hold in DONE with decoder stalled
      bus.IDU_ready     = 1'b0;
      bus.next_pc_valid = 1'b1;
      bus.next_pc       = 32'h8000_0004;
      exp_addr_q.push_back(32'h8000_0004);
      exp_xfer_q.push_back({32'h8000_0004, 32'h00a0_0093});
      step();
      bus.next_pc_valid = 1'b0;
      fetch_from_req(32'h00a0_0093, 2);
      for (int i = 0; i < 5; i++) begin
         bus.imem_rsp_valid = i[0];
         bus.imem_rdata     = $urandom;
         step();
         check("hold_done", {31'd0, bus.IFU_done}, 32'd1);
         check("hold_instr", bus.instruction, 32'h00a0_0093);
         check("hold_pc", bus.pc, 32'h8000_0004);
      end
      bus.imem_rsp_valid = 1'b0;

      // next_pc in the transfer cycle goes straight to REQ
      bus.IDU_ready     = 1'b1;
      bus.next_pc_valid = 1'b1;
      bus.next_pc       = 32'h8000_0010;
      exp_addr_q.push_back(32'h8000_0010);
      exp_xfer_q.push_back({32'h8000_0010, 32'h0010_0093});
      step();
      bus.IDU_ready     = 1'b0;
      bus.next_pc_valid = 1'b0;
      check("nodwell_req", {31'd0, bus.imem_req_valid}, 32'd1);
      check("nodwell_addr", bus.imem_addr, 32'h8000_0010);
      check("nodwell_cnt", bus.fetch_cnt, 32'd2);

      // response arriving in the timeout cycle wins
      fetch_from_req(32'h0010_0093, 255);
      check("edge_rsp_done", {31'd0, bus.IFU_done}, 32'd1);
      check("edge_rsp_err", {31'd0, bus.fetch_err}, 32'd0);

      // reset during WAIT with a stale response afterwards
      bus.IDU_ready     = 1'b1;
      bus.next_pc_valid = 1'b1;
      bus.next_pc       = 32'h8000_0014;
      exp_addr_q.push_back(32'h8000_0014);
      step();
      bus.IDU_ready     = 1'b0;
      bus.next_pc_valid = 1'b0;
      check("pre_rst_cnt", bus.fetch_cnt, 32'd3);
      step();
      #2 rst_n = 1'b0;
      #1;
      check("midrst_cnt", bus.fetch_cnt, 32'd0);
      check("midrst_pc", bus.pc, 32'h8000_0000);
      check("midrst_req", {31'd0, bus.imem_req_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rdata     = 32'hdead_beef;
      bus.imem_req_ready = 1'b0;
      exp_addr_q.push_back(32'h8000_0000);
      exp_xfer_q.push_back({32'h8000_0000, 32'h0000_0013});
      step();
      check("stale_req", {31'd0, bus.imem_req_valid}, 32'd1);
      check("stale_addr", bus.imem_addr, 32'h8000_0000);
      step();
      check("stale_still_req", {31'd0, bus.imem_req_valid}, 32'd1);
      check("stale_done", {31'd0, bus.IFU_done}, 32'd0);
      bus.imem_rsp_valid = 1'b0;
      bus.imem_req_ready = 1'b1;
      fetch_from_req(32'h0000_0013, 1);
      check("postrst_instr", bus.instruction, 32'h0000_0013);
      check("postrst_cnt", bus.fetch_cnt, 32'd0);

      // WAIT timeout after 256 silent cycles
      bus.IDU_ready = 1'b1;
      step();
      bus.IDU_ready = 1'b0;
      check("to_cnt", bus.fetch_cnt, 32'd1);
      bus.next_pc_valid = 1'b1;
      bus.next_pc       = 32'h8000_0020;
      exp_addr_q.push_back(32'h8000_0020);
      step();
      bus.next_pc_valid = 1'b0;
      step();
      repeat (255) step();
      check("to_not_early", {31'd0, bus.fetch_err}, 32'd0);
      step();
      check("to_err", {31'd0, bus.fetch_err}, 32'd1);
      check("to_req", {31'd0, bus.imem_req_valid}, 32'd0);
      check("to_done", {31'd0, bus.IFU_done}, 32'd0);

      // misaligned next_pc is terminal
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_addr_q.push_back(32'h8000_0000);
      exp_xfer_q.push_back({32'h8000_0000, 32'h0000_0513});
      step();
      fetch_from_req(32'h0000_0513, 0);
      bus.IDU_ready     = 1'b1;
      bus.next_pc_valid = 1'b1;
      bus.next_pc       = 32'h8000_0006;
      step();
      check("mis_err", {31'd0, bus.fetch_err}, 32'd1);
      check("mis_pc", bus.pc, 32'h8000_0006);
      check("mis_req", {31'd0, bus.imem_req_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         bus.imem_rsp_valid = 1'b1;
         bus.next_pc_valid  = 1'b1;
         bus.next_pc        = 32'h8000_0100;
         step();
         check("err_sticky", {31'd0, bus.fetch_err}, 32'd1);
         check("err_req", {31'd0, bus.imem_req_valid}, 32'd0);
         check("err_done", {31'd0, bus.IFU_done}, 32'd0);
         check("err_pc", bus.pc, 32'h8000_0006);
      end
      bus.imem_rsp_valid = 1'b0;
      bus.next_pc_valid  = 1'b0;
      bus.IDU_ready      = 1'b0;
      step();

      check("sb_addr_empty", exp_addr_q.size(), 32'd0);
      check("sb_xfer_empty", exp_xfer_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000: address of the first fetch after reset.
REQ-002 Parameter MAX_WAIT, default 255: maximum cycles spent in WAIT before timeout.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  fetch address; equals pc while imem_req_valid=1.
REQ-007 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-008 imem_rsp_valid  input  1  imem_rdata is valid this cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 instruction  output  32  instruction handed to the decoder.
REQ-011 pc  output  32  address of the current or held instruction.
REQ-012 IFU_done  output  1  instruction valid toward the decoder.
REQ-013 IDU_ready  input  1  decoder accepts the instruction this cycle.
REQ-014 next_pc_valid  input  1  next_pc is valid (from writeback).
REQ-015 next_pc  input  32  address of the next fetch.
REQ-016 fetch_err  output  1  sticky error flag.
REQ-017 fetch_cnt  output  32  count of instructions handed off.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT, DONE, WAIT_PC and ERR, all registered.
REQ-019 IDLE SHALL go to REQ unconditionally one cycle after reset release.
REQ-020 In REQ, imem_req_valid SHALL be 1; on imem_req_ready=1, go to WAIT and clear the wait counter.
REQ-021 imem_rsp_valid SHALL be ignored in every state except WAIT.
REQ-022 In WAIT, on imem_rsp_valid=1: capture imem_rdata into instruction; go to DONE.
REQ-023 In WAIT without imem_rsp_valid, the 8-bit wait counter SHALL increment.
- When the counter equals MAX_WAIT, go to ERR.
- imem_rsp_valid arriving in that same cycle takes priority (go to DONE).
REQ-024 In DONE, IFU_done SHALL be 1, and instruction and pc SHALL stay stable until IDU_ready=1.
REQ-025 The decoder transfer SHALL occur on IFU_done=1 and IDU_ready=1 in the same cycle.
- fetch_cnt increments by 1, wrapping modulo 2^32.
- Go to WAIT_PC.
REQ-026 next_pc_valid in the same cycle as a DONE transfer SHALL be captured as if it arrived in WAIT_PC (load pc, go to REQ).
REQ-027 In WAIT_PC, on next_pc_valid=1: pc <= next_pc, then go to REQ.
- If next_pc[1:0] != 0, go to ERR instead; pc still loads next_pc.
REQ-028 next_pc_valid SHALL be ignored in IDLE, REQ, WAIT and ERR.
REQ-029 ERR SHALL be terminal until reset.
- fetch_err=1.
- IFU_done=0 and imem_req_valid=0.
REQ-030 imem_req_valid and IFU_done SHALL be decoded from the state register only, with no combinational path from any input.
REQ-031 Best-case latency from reset release to IFU_done=1, with req_ready=1 and the response one cycle after acceptance, SHALL be 4 cycles.
REQ-032 At most one request SHALL be outstanding at any time.

Reset
REQ-033 While rst_n=0, outputs SHALL be:
- state=IDLE, pc=RESET_PC, instruction=0, fetch_cnt=0, wait counter=0;
- imem_req_valid=0, IFU_done=0, fetch_err=0.
REQ-034 Reset asserted during WAIT SHALL abandon the outstanding request; a response arriving after reset release, before the new REQ is accepted, SHALL be ignored.
REQ-035 Reset assertion SHALL take effect immediately, independent of clk.

Verification
REQ-036 Reset release, req_ready=1, rsp_valid=1 one cycle after acceptance with rdata=32'h00000413, IDU_ready=1 -> imem_addr=32'h8000_0000; IFU_done=1 at cycle 4 with instruction=32'h00000413; fetch_cnt=1.
REQ-037 IDU_ready held 0 for 5 cycles in DONE while imem_rdata changes -> instruction and pc unchanged, IFU_done=1 throughout; transfer on the cycle IDU_ready rises.
REQ-038 next_pc_valid=1, next_pc=32'h8000_0010 in the same cycle as the transfer -> next imem_addr=32'h8000_0010; no WAIT_PC dwell.
REQ-039 next_pc=32'h8000_0006 -> fetch_err=1, no further imem_req_valid, IFU_done=0; later rsp_valid and next_pc_valid ignored.
REQ-040 No response for 256 cycles in WAIT -> fetch_err=1 exactly when the counter reaches 255; rsp_valid on that same cycle -> DONE instead, fetch_err=0.
REQ-041 rst_n pulsed low during WAIT, stale rsp_valid after release -> ignored; first new fetch at 32'h8000_0000; fetch_cnt=0.
